data_mem_unit: RTL and testbench

Parametrised, handshaked data-memory unit for the femtoRV32 load/store path. It replaces the combinational-read byte memory with:
- a word-organised synchronous RAM;
- a valid/ready request/response protocol;
- address range and alignment checking;
- correct sign extension for LB/LH.

It sits between the execute stage's load/store logic and on-chip data storage.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_bank.sv | 33 +++
 rtl/data_mem_unit.sv | 174 +++++++++++++++++
 tb/tb_data_mem_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the femtoRV32 data-memory unit: size encodings, FSM states
// and the byte-lane helpers used by data_mem_unit.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } dmem_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_WORD: return 3'd4;
            SZ_HALF: return 3'd2;
            SZ_BYTE: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Byte enables across two consecutive words: [3:0] first word, [7:4] second word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_WORD: base = 8'h0F;
            SZ_HALF: base = 8'h03;
            SZ_BYTE: base = 8'h01;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read that
// only updates when re is high, so the read word stays put while the response waits.
module dmem_bank #(
    parameter int WORDS = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [3:0]               be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[addr];
        end
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Handshaked data-memory unit: IDLE/ACC0/ACC1/RESP FSM, range/alignment checks, lane merge
// and load extraction. Define DMEM_MISALIGN_SPLIT_EN to perform misaligned half/word accesses.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WAW   = $clog2(WORDS);

    dmem_state_e      state_q, state_d;
    logic             write_q, signed_q, err_q;
    logic [1:0]       size_q;
    logic [WAW+1:0]   addr_q;
    logic [31:0]      wdata_q;

    logic [2:0]       req_n;
    logic [ADDR_W:0]  req_last;
    logic             req_fault;

    logic             bank_we, bank_re;
    logic [3:0]       bank_be;
    logic [WAW-1:0]   bank_addr;
    logic [31:0]      bank_wdata, bank_rdata;

    logic [7:0]       mask8;
    logic [63:0]      data64;
    logic [63:0]      rd64;
    logic [31:0]      shifted;
    logic [31:0]      load_val;

    // Range is checked on the last touched byte, one bit wider so the sum cannot wrap.
    assign req_n    = size_bytes(req_size);
    assign req_last = {1'b0, req_addr} + (ADDR_W+1)'(req_n - 3'd1);

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic        split_q;
    logic        req_cross;
    logic [31:0] lo_word_q;

    assign req_cross = ({2'b00, req_addr[1:0]} + {1'b0, req_n}) > 4'd4;
    assign req_fault = (req_size == SZ_ILL) || (req_last >= (ADDR_W+1)'(DEPTH_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q   <= 1'b0;
            lo_word_q <= '0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                split_q <= req_cross;
            end
            if (state_q == ST_ACC1) begin
                lo_word_q <= bank_rdata;
            end
        end
    end
`else
    logic req_misaligned;
    logic unused_hi;

    assign req_misaligned = (req_size == SZ_HALF && req_addr[0]) ||
                            (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign req_fault = (req_size == SZ_ILL) || (req_last >= (ADDR_W+1)'(DEPTH_BYTES)) ||
                       req_misaligned;
    assign unused_hi = ^{mask8[7:4], data64[63:32]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= SZ_WORD;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_fault;
                size_q   <= req_size;
                addr_q   <= req_addr[WAW+1:0];
                wdata_q  <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = req_fault ? ST_RESP : ST_ACC0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_ACC0: state_d = split_q ? ST_ACC1 : ST_RESP;
`else
            ST_ACC0: state_d = ST_RESP;
`endif
            ST_ACC1: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Store data is pre-shifted into a two-word window; ACC0 uses the low word, ACC1 the high.
    always_comb begin
        mask8      = lane_mask(size_q, addr_q[1:0]);
        data64     = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
        bank_addr  = addr_q[WAW+1:2];
        bank_be    = mask8[3:0];
        bank_wdata = data64[31:0];
        bank_we    = 1'b0;
        bank_re    = 1'b0;
        if (state_q == ST_ACC0) begin
            bank_we = write_q;
            bank_re = !write_q;
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_q == ST_ACC1) begin
            bank_addr  = addr_q[WAW+1:2] + WAW'(1);
            bank_be    = mask8[7:4];
            bank_wdata = data64[63:32];
            bank_we    = write_q;
            bank_re    = !write_q;
        end
`endif
    end

    dmem_bank #(.WORDS(WORDS)) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .re    (bank_re),
        .be    (bank_be),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    always_comb begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        rd64 = split_q ? {bank_rdata, lo_word_q} : {32'b0, bank_rdata};
`else
        rd64 = {32'b0, bank_rdata};
`endif
        shifted = 32'(rd64 >> {addr_q[1:0], 3'b000});
        case (size_q)
            SZ_BYTE: load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = (state_q == ST_RESP && !err_q && !write_q) ? load_val : 32'h0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: byte-array reference model, directed cases plus random traffic.
module tb_data_mem_unit;

    localparam int DEPTH = 256;
    localparam int AW    = 32;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    data_mem_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];
    int          exp_lat_q[$];
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_access(input logic w, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        longint      last;
        bit          err;
        int          lat;
        logic [31:0] val;
        n   = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 0;
        err = (size == 2'd3);
        if (!err) begin
            last = longint'(addr) + n - 1;
            if (last >= DEPTH) err = 1'b1;
            if (!SPLIT && (int'(addr[1:0]) % n) != 0) err = 1'b1;
        end
        lat = err ? 1 : ((int'(addr[1:0]) + n > 4) ? 3 : 2);
        val = 32'h0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[addr + i]) << (8*i));
                if (sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
            end
        end
        exp_q.push_back(val);
        exp_err_q.push_back({31'b0, err});
        exp_lat_q.push_back(lat);
    endtask

    // driver: one request/response, response held back for 'hold' cycles
    task automatic do_req(input logic w, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input string tag, output logic [31:0] rd);
        logic [31:0] e_rd, e_err;
        int          e_lat, lat;
        ref_access(w, size, sgn, addr, wdata);
        e_rd  = exp_q.pop_front();
        e_err = exp_err_q.pop_front();
        e_lat = exp_lat_q.pop_front();
        @(negedge clk);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
        end while (!rsp_valid && lat < 10);
        check({tag, "_lat"}, 32'(lat), 32'(e_lat));
        check({tag, "_err"}, {31'b0, rsp_err}, e_err);
        check({tag, "_rdata"}, rsp_rdata, e_rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, e_rd);
            check({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rd = rsp_rdata;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"},   {31'b0, rsp_err},   32'd0);
    endtask

    logic [31:0] rd;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // preload every word so the model knows all contents
        for (int a = 0; a < DEPTH; a += 4) begin
            do_req(1'b1, 2'b00, 1'b0, 32'(a), $urandom, 0, "init", rd);
        end

        do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h8899AABB, 0, "sw10", rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, "lw10", rd);
        check("lw10_value", rd, 32'h8899AABB);
        do_req(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 0, "lb13", rd);
        check("lb13_value", rd, 32'hFFFFFF88);
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, "lbu13", rd);
        check("lbu13_value", rd, 32'h00000088);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, "lh10", rd);
        check("lh10_value", rd, 32'hFFFFAABB);
        do_req(1'b1, 2'b10, 1'b0, 32'h11, 32'h7F, 0, "sb11", rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, "lw10_sb", rd);
        check("lw10_sb_value", rd, 32'h88997FBB);

        do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, "lw_oor", rd);
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sz11_st", rd);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, "sz11_ld", rd);
        do_req(1'b1, 2'b00, 1'b0, 32'hFFFFFFFC, 32'h12345678, 0, "sw_wrap", rd);
        do_req(1'b1, 2'b01, 1'b0, 32'hFF, 32'h5555, 0, "sh_edge", rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, "lw10_after_err", rd);
        check("lw10_unchanged", rd, 32'h88997FBB);

        do_req(1'b1, 2'b00, 1'b0, 32'h0E, 32'h11223344, 0, "sw_mis", rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 0, "lw0c", rd);
`ifdef DMEM_MISALIGN_SPLIT_EN
        check("lw0c_hi_bytes", {16'b0, rd[31:16]}, 32'h3344);
`endif
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, "lw10_mis", rd);
`ifdef DMEM_MISALIGN_SPLIT_EN
        check("lw10_lo_bytes", {16'b0, rd[15:0]}, 32'h1122);
`else
        check("lw10_no_split", rd, 32'h88997FBB);
`endif
        do_req(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 0, "lw_mis", rd);
        do_req(1'b0, 2'b01, 1'b1, 32'h0F, 32'h0, 0, "lh_mis3", rd);
        do_req(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0, 0, "lh_mis1", rd);

        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 5, "hold5", rd);

        // reset during ACC0 of a load
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("acc0_busy", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset_rel");
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, "lw10_post_rst", rd);

        for (int k = 0; k < 300; k++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, DEPTH + 6)), $urandom,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                   "rand", rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
